ks_add_arbiter: RTL and testbench

Shares one instance of the team's 16-bit Kogge-Stone adder among four requesters. Each requester presents an operand pair. A round-robin arbiter grants one request per cycle into a two-stage pipeline: operand register, then result register. The tagged result is returned on a single response channel with valid/ready backpressure. The block sits between the client ports and the adder and is the only block that drives the adder's inputs.

---
 rtl/ks_add_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ks_add_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_add_arbiter.sv
// Four-way round-robin front end sharing one 16-bit Kogge-Stone adder.
// Two-stage pipeline (operands, then result) with valid/ready on the response side.

module ks_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);
    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;
endmodule

module ks_adder16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int LV = $clog2(W);

    logic [LV:0][W-1:0] g;
    logic [LV:0][W-1:0] p;
    logic               unused_p;

    assign g[0] = a & b;
    assign p[0] = a ^ b;

    // Level lv combines each bit with the group 2^lv positions below it.
    for (genvar lv = 0; lv < LV; lv++) begin : g_lvl
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i >= (1 << lv)) begin : g_cell
                ks_cell u_cell (
                    .g_hi  (g[lv][i]),
                    .p_hi  (p[lv][i]),
                    .g_lo  (g[lv][i-(1<<lv)]),
                    .p_lo  (p[lv][i-(1<<lv)]),
                    .g_out (g[lv+1][i]),
                    .p_out (p[lv+1][i])
                );
            end else begin : g_pass
                assign g[lv+1][i] = g[lv][i];
                assign p[lv+1][i] = p[lv][i];
            end
        end
    end

    assign sum      = p[0] ^ {g[LV][W-2:0], 1'b0};
    assign cout     = g[LV][W-1];
    assign unused_p = ^p[LV];
endmodule

module ks_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_carry
);
    localparam int IW = 2;

    logic [N_REQ-1:0][W-1:0] ops_a;
    logic [N_REQ-1:0][W-1:0] ops_b;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           scan;
    logic [IW-1:0]           grant_idx;
    logic                    grant_any;
    logic                    accept;
    logic                    s2_free;
    logic                    s1_adv;
    logic                    s1_load_ok;

    logic                    s1_valid;
    logic [W-1:0]            s1_a;
    logic [W-1:0]            s1_b;
    logic [IW-1:0]           s1_id;

    logic [W-1:0]            add_sum;
    logic                    add_carry;
    logic                    unused_cout;

    assign ops_a = req_a;
    assign ops_b = req_b;

    assign s2_free    = !rsp_valid || rsp_ready;
    assign s1_adv     = s1_valid && s2_free;
    assign s1_load_ok = !s1_valid || s2_free;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr;
        scan      = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            scan = ptr + IW'(k);
            if (!grant_any && req_valid[scan]) begin
                grant_any = 1'b1;
                grant_idx = scan;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && grant_any && s1_load_ok)
            req_ready[grant_idx] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    ks_adder16 #(.W(W)) u_add (
        .a    (s1_a),
        .b    (s1_b),
        .sum  (add_sum),
        .cout (unused_cout)
    );

    // Carry recovered from the operand MSBs and the sum MSB.
    assign add_carry = (s1_a[W-1] & s1_b[W-1]) |
                       ((s1_a[W-1] ^ s1_b[W-1]) & ~add_sum[W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else begin
            if (accept) begin
                ptr      <= grant_idx + IW'(1);
                s1_valid <= 1'b1;
                s1_a     <= ops_a[grant_idx];
                s1_b     <= ops_b[grant_idx];
                s1_id    <= grant_idx;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (s1_adv) begin
                rsp_valid <= 1'b1;
                rsp_sum   <= add_sum;
                rsp_carry <= add_carry;
                rsp_id    <= s1_id;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ks_add_arbiter.sv
// Scoreboard bench for ks_add_arbiter: expected results queued at accept, checked at response.

module tb_ks_add_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_carry;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        carry;
    } rsp_t;

    rsp_t       sb_q[$];
    rsp_t       rsp_log[$];
    int         acc_log[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] acc_mask = '0;
    rsp_t       mon_cur, mon_exp, prev;
    bit         prev_stall = 0;

    initial forever #5 clk = ~clk;

    ks_add_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
    );

    function automatic rsp_t model(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        model.id    = id;
        model.sum   = s[15:0];
        model.carry = s[16];
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from input changes.
    initial begin : monitor
        forever begin
            @(negedge clk);
            acc_mask = req_valid & req_ready;
            if (rst === 1'b1) begin
                sb_q.delete();
                prev_stall = 0;
            end else begin
                checks++;
                if ($countones(req_ready) > 1) begin
                    failures++;
                    $display("FAIL ready_onehot got=%b", req_ready);
                end
                mon_cur = {rsp_id, rsp_sum, rsp_carry};
                if (prev_stall) begin
                    checks++;
                    if (rsp_valid !== 1'b1 || mon_cur !== prev) begin
                        failures++;
                        $display("FAIL stall_hold got v=%b %h want v=1 %h", rsp_valid, mon_cur, prev);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_rsp got id=%0d sum=%h c=%b want none", rsp_id, rsp_sum, rsp_carry);
                    end else begin
                        mon_exp = sb_q.pop_front();
                        if (mon_cur !== mon_exp) begin
                            failures++;
                            $display("FAIL sb_rsp got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                                     rsp_id, rsp_sum, rsp_carry, mon_exp.id, mon_exp.sum, mon_exp.carry);
                        end
                    end
                    rsp_log.push_back(mon_cur);
                end
                for (int i = 0; i < 4; i++) begin
                    if (acc_mask[i]) begin
                        sb_q.push_back(model(2'(i), req_a[16*i +: 16], req_b[16*i +: 16]));
                        acc_log.push_back(i);
                    end
                end
                prev_stall = rsp_valid && !rsp_ready;
                prev = mon_cur;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh_accepted();
        for (int i = 0; i < 4; i++)
            if (acc_mask[i]) begin
                req_a[16*i +: 16] = 16'($urandom);
                req_b[16*i +: 16] = 16'($urandom);
            end
    endtask

    task automatic offer(input int id, input logic [15:0] a, input logic [15:0] b, output bit ok);
        req_valid[id] = 1'b1;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1;
            tick();
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (!rsp_valid && !dut.s1_valid && sb_q.size() == 0) ok = 1;
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++;
        if ({rsp_id, rsp_sum, rsp_carry} !== 19'd0) begin
            failures++; $display("FAIL reset_rsp_data got id=%0d sum=%h c=%b want 0", rsp_id, rsp_sum, rsp_carry);
        end
        checks++;
        if (dut.ptr !== 2'd0 || dut.s1_valid !== 1'b0) begin
            failures++; $display("FAIL reset_state got ptr=%0d s1v=%b want 0/0", dut.ptr, dut.s1_valid);
        end
        req_valid = 4'h0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        req_a[47:32] = 16'h1234;
        req_b[47:32] = 16'h0FCC;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b want=0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b want=0", rsp_valid); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 16'h2200 || rsp_carry !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp got v=%b id=%0d sum=%h c=%b want v=1 id=2 sum=2200 c=0",
                     rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
        tick();
    endtask

    task automatic test_carry();
        bit ok;
        logic [15:0] ea [3] = '{16'hFFFF, 16'h8000, 16'hAAAA};
        logic [15:0] eb [3] = '{16'h0001, 16'h8000, 16'h5555};
        logic [15:0] es [3] = '{16'h0000, 16'h0000, 16'hFFFF};
        logic        ec [3] = '{1'b1, 1'b1, 1'b0};
        wait_idle(ok);
        rsp_log.delete();
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            offer(0, ea[k], eb[k], ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL carry_accept%0d got=timeout want=accept", k); end
        end
        wait_idle(ok);
        checks++;
        if (rsp_log.size() != 3) begin
            failures++; $display("FAIL carry_count got=%0d want=3", rsp_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rsp_log[k].sum !== es[k] || rsp_log[k].carry !== ec[k] || rsp_log[k].id !== 2'd0) begin
                    failures++;
                    $display("FAIL carry_rsp%0d got id=%0d sum=%h c=%b want id=0 sum=%h c=%b",
                             k, rsp_log[k].id, rsp_log[k].sum, rsp_log[k].carry, es[k], ec[k]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int rv_cnt = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_log.delete();
        acc_log.delete();
        rsp_ready = 1'b1;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_valid = 4'hF;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && rsp_valid) rv_cnt++;
            tick();
            refresh_accepted();
        end
        req_valid = 4'h0;
        wait_idle(ok);
        checks++;
        if (rv_cnt != 14) begin failures++; $display("FAIL rr_rate got=%0d want=14", rv_cnt); end
        checks++;
        if (acc_log.size() != 16 || rsp_log.size() != 16) begin
            failures++; $display("FAIL rr_count got acc=%0d rsp=%0d want 16/16", acc_log.size(), rsp_log.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (acc_log[k] != k % 4 || rsp_log[k].id !== 2'(k % 4)) begin
                    failures++;
                    $display("FAIL rr_order%0d got grant=%0d rsp_id=%0d want=%0d", k, acc_log[k], rsp_log[k].id, k % 4);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        wait_idle(ok);
        acc_log.delete();
        rsp_log.delete();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            tick();
            refresh_accepted();
        end
        @(negedge clk);
        checks++;
        if (acc_log.size() != 2) begin failures++; $display("FAIL bp_accepts got=%0d want=2", acc_log.size()); end
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
            failures++; $display("FAIL bp_stall got ready=%b v=%b want 0000/1", req_ready, rsp_valid);
        end
        tick();
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            tick();
            refresh_accepted();
        end
        req_valid = 4'h0;
        wait_idle(ok);
        checks++;
        if (!ok || rsp_log.size() != acc_log.size()) begin
            failures++; $display("FAIL bp_drain got rsp=%0d want=%0d", rsp_log.size(), acc_log.size());
        end
    endtask

    task automatic test_reset_midflight();
        bit ok0, ok1;
        wait_idle(ok0);
        rsp_ready = 1'b0;
        offer(0, 16'h1111, 16'h2222, ok0);
        offer(3, 16'h3333, 16'h4444, ok1);
        checks++;
        if (!ok0 || !ok1) begin failures++; $display("FAIL mid_accept got=%b%b want=11", ok0, ok1); end
        rsp_log.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        req_a[31:16] = 16'h0101;
        req_b[31:16] = 16'h00FF;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || dut.ptr !== 2'd0 || dut.s1_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_flush got v=%b ptr=%0d s1v=%b want 0/0/0", rsp_valid, dut.ptr, dut.s1_valid);
        end
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_resume got=%b want=0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        wait_idle(ok0);
        checks++;
        if (rsp_log.size() != 1) begin
            failures++; $display("FAIL mid_count got=%0d want=1", rsp_log.size());
        end else begin
            checks++;
            if (rsp_log[0].id !== 2'd1 || rsp_log[0].sum !== 16'h0200 || rsp_log[0].carry !== 1'b0) begin
                failures++;
                $display("FAIL mid_rsp got id=%0d sum=%h c=%b want id=1 sum=0200 c=0",
                         rsp_log[0].id, rsp_log[0].sum, rsp_log[0].carry);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int waits [4] = '{0, 0, 0, 0};
        logic [3:0] acc = '0;
        wait_idle(ok);
        rsp_log.delete();
        acc_log.delete();
        for (int cyc = 0; cyc < 60000 && acc_log.size() < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_a[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    req_b[16*i +: 16] = 16'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = req_valid & req_ready;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    checks++;
                    if (waits[i] > 3) begin failures++; $display("FAIL fairness req%0d got=%0d want<=3", i, waits[i]); end
                    waits[i] = 0;
                end else if (req_valid[i] && acc != 4'b0) begin
                    waits[i]++;
                end
            end
            tick();
        end
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok || sb_q.size() != 0) begin failures++; $display("FAIL rand_drain got pending=%0d want=0", sb_q.size()); end
        checks++;
        if (acc_log.size() < 10000 || rsp_log.size() != acc_log.size()) begin
            failures++; $display("FAIL rand_count got acc=%0d rsp=%0d want >=10000 and equal", acc_log.size(), rsp_log.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
